// File: rtl/idli_de_m.sv
// Decode stage: assembles four 4b nibbles (LSB first) into a 16b op and holds it
// in a single output register under a valid/accept handshake with execute.
//
// state | meaning
// ASM0  | waiting for nibble 0 (bits [3:0], field c)
// ASM1  | waiting for nibble 1 (bits [7:4], field b)
// ASM2  | waiting for nibble 2 (bits [11:8], field a)
// ASM3  | waiting for final nibble (bits [15:12], opc); stalls while output is held
module idli_de_m (
   input  logic        i_de_gck,
   input  logic        i_de_rst,
   input  logic [3:0]  i_de_instr,
   input  logic        i_de_instr_vld,
   output logic        o_de_instr_acp,
   input  logic        i_de_flush,
   output logic [15:0] o_de_op,
   output logic        o_de_op_vld,
   input  logic        i_de_op_acp
);

   typedef enum logic [1:0] {ASM0, ASM1, ASM2, ASM3} asm_state_t;

   asm_state_t  r_state;
   asm_state_t  w_state_nxt;
   logic [11:0] r_asm;
   logic        w_out_free;
   logic        w_xfer;
   logic        w_complete;

   assign w_out_free = !o_de_op_vld || i_de_op_acp;
   assign w_xfer     = i_de_instr_vld && o_de_instr_acp;
   assign w_complete = w_xfer && (r_state == ASM3);

   always_ff @(posedge i_de_gck) begin
      if (i_de_rst) begin
         r_state <= ASM0;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_de_flush) begin
         w_state_nxt = ASM0;
      end else if (w_xfer) begin
         case (r_state)
            ASM0:    w_state_nxt = ASM1;
            ASM1:    w_state_nxt = ASM2;
            ASM2:    w_state_nxt = ASM3;
            default: w_state_nxt = ASM0;
         endcase
      end
   end

   // Acceptance depends only on state, flush and the execute side, never on i_de_instr_vld.
   always_comb begin
      o_de_instr_acp = 1'b0;
      if (!i_de_flush) begin
         o_de_instr_acp = (r_state != ASM3) || w_out_free;
      end
   end

   always_ff @(posedge i_de_gck) begin
      if (i_de_rst) begin
         r_asm <= 12'h000;
      end else if (w_xfer) begin
         case (r_state)
            ASM0:    r_asm[3:0]  <= i_de_instr;
            ASM1:    r_asm[7:4]  <= i_de_instr;
            ASM2:    r_asm[11:8] <= i_de_instr;
            default: r_asm       <= r_asm;
         endcase
      end
   end

   // The final nibble goes straight into the output register, never into r_asm.
   always_ff @(posedge i_de_gck) begin
      if (i_de_rst) begin
         o_de_op     <= 16'h0000;
         o_de_op_vld <= 1'b0;
      end else if (i_de_flush) begin
         o_de_op_vld <= 1'b0;
      end else if (w_complete) begin
         o_de_op     <= {i_de_instr, r_asm};
         o_de_op_vld <= 1'b1;
      end else if (i_de_op_acp) begin
         o_de_op_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_idli_de_m.sv
// Directed bench for idli_de_m: each task drives one scenario and checks inline
// against hand-computed values.
module tb_idli_de_m;

   logic        clk;
   logic        rst;
   logic [3:0]  instr;
   logic        instr_vld;
   logic        instr_acp;
   logic        flush;
   logic [15:0] op;
   logic        op_vld;
   logic        op_acp;

   int n_vec = 0;
   int n_err = 0;

   idli_de_m dut (
      .i_de_gck       (clk),
      .i_de_rst       (rst),
      .i_de_instr     (instr),
      .i_de_instr_vld (instr_vld),
      .o_de_instr_acp (instr_acp),
      .i_de_flush     (flush),
      .o_de_op        (op),
      .o_de_op_vld    (op_vld),
      .i_de_op_acp    (op_acp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_nib(input logic [3:0] n);
      instr     = n;
      instr_vld = 1'b1;
      step();
      instr_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_vec++;
      if (op_vld !== 1'b0) begin
         n_err++; $display("FAIL reset_vld got=%b exp=0", op_vld);
      end
      n_vec++;
      if (op !== 16'h0000) begin
         n_err++; $display("FAIL reset_op got=%h exp=0000", op);
      end
      n_vec++;
      if (instr_acp !== 1'b1) begin
         n_err++; $display("FAIL reset_acp got=%b exp=1", instr_acp);
      end
   endtask

   task automatic test_basic();
      logic [3:0] nibs [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
      op_acp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instr = nibs[i]; instr_vld = 1'b1;
         n_vec++;
         if (instr_acp !== 1'b1) begin
            n_err++; $display("FAIL basic_acp%0d got=%b exp=1", i, instr_acp);
         end
         n_vec++;
         if (op_vld !== 1'b0) begin
            n_err++; $display("FAIL basic_early_vld%0d got=%b exp=0", i, op_vld);
         end
         step();
      end
      instr_vld = 1'b0;
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'h1234) begin
         n_err++; $display("FAIL basic_op got=%b/%h exp=1/1234", op_vld, op);
      end
      step();
      n_vec++;
      if (op_vld !== 1'b0) begin
         n_err++; $display("FAIL basic_vld_clear got=%b exp=0", op_vld);
      end
   endtask

   task automatic test_stall();
      op_acp = 1'b0;
      send_nib(4'h4); send_nib(4'h3); send_nib(4'h2); send_nib(4'h1);
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'h1234) begin
         n_err++; $display("FAIL stall_first got=%b/%h exp=1/1234", op_vld, op);
      end
      send_nib(4'hF); send_nib(4'hE); send_nib(4'hD);
      instr = 4'hC; instr_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (instr_acp !== 1'b0) begin
            n_err++; $display("FAIL stall_acp%0d got=%b exp=0", i, instr_acp);
         end
         step();
         n_vec++;
         if (op_vld !== 1'b1 || op !== 16'h1234) begin
            n_err++; $display("FAIL stall_hold%0d got=%b/%h exp=1/1234", i, op_vld, op);
         end
      end
      op_acp = 1'b1;
      #1;
      n_vec++;
      if (instr_acp !== 1'b1) begin
         n_err++; $display("FAIL stall_release_acp got=%b exp=1", instr_acp);
      end
      step();
      instr_vld = 1'b0;
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'hCDEF) begin
         n_err++; $display("FAIL stall_second got=%b/%h exp=1/cdef", op_vld, op);
      end
      step();
      n_vec++;
      if (op_vld !== 1'b0) begin
         n_err++; $display("FAIL stall_drain got=%b exp=0", op_vld);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] nibs [8] = '{4'h5, 4'hA, 4'h5, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0};
      op_acp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         instr = nibs[i]; instr_vld = 1'b1;
         step();
         n_vec++;
         if (op_vld !== ((i == 3) || (i == 7))) begin
            n_err++; $display("FAIL b2b_vld%0d got=%b", i, op_vld);
         end
         if (i == 3) begin
            n_vec++;
            if (op !== 16'hA5A5) begin
               n_err++; $display("FAIL b2b_op0 got=%h exp=a5a5", op);
            end
         end
         if (i == 7) begin
            n_vec++;
            if (op !== 16'h0F0F) begin
               n_err++; $display("FAIL b2b_op1 got=%h exp=0f0f", op);
            end
         end
      end
      instr_vld = 1'b0;
      step();
   endtask

   task automatic test_flush();
      op_acp = 1'b1;
      send_nib(4'h1); send_nib(4'h2);
      instr = 4'h9; instr_vld = 1'b1; flush = 1'b1;
      #1;
      n_vec++;
      if (instr_acp !== 1'b0) begin
         n_err++; $display("FAIL flush_acp got=%b exp=0", instr_acp);
      end
      step();
      flush = 1'b0; instr_vld = 1'b0;
      send_nib(4'h8); send_nib(4'h7); send_nib(4'h6);
      n_vec++;
      if (op_vld !== 1'b0) begin
         n_err++; $display("FAIL flush_early_vld got=%b exp=0", op_vld);
      end
      send_nib(4'h5);
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'h5678) begin
         n_err++; $display("FAIL flush_op got=%b/%h exp=1/5678", op_vld, op);
      end
      step();
   endtask

   task automatic test_flush_held();
      op_acp = 1'b0;
      send_nib(4'h1); send_nib(4'h1); send_nib(4'h1); send_nib(4'h1);
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'h1111) begin
         n_err++; $display("FAIL fheld_op got=%b/%h exp=1/1111", op_vld, op);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_vec++;
      if (op_vld !== 1'b0) begin
         n_err++; $display("FAIL fheld_vld got=%b exp=0", op_vld);
      end
   endtask

   task automatic test_reset_mid();
      op_acp = 1'b0;
      send_nib(4'h2); send_nib(4'h2); send_nib(4'h2); send_nib(4'h2);
      send_nib(4'h3); send_nib(4'h3); send_nib(4'h3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++;
      if (op_vld !== 1'b0 || op !== 16'h0000) begin
         n_err++; $display("FAIL rmid_out got=%b/%h exp=0/0000", op_vld, op);
      end
      n_vec++;
      if (instr_acp !== 1'b1) begin
         n_err++; $display("FAIL rmid_acp got=%b exp=1", instr_acp);
      end
      op_acp = 1'b1;
      send_nib(4'h9); send_nib(4'hA); send_nib(4'hB); send_nib(4'hC);
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'hCBA9) begin
         n_err++; $display("FAIL rmid_op got=%b/%h exp=1/cba9", op_vld, op);
      end
      step();
   endtask

   task automatic test_gaps();
      logic [3:0] nibs [4] = '{4'hF, 4'hE, 4'hE, 4'hB};
      op_acp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int gap;
         gap = $urandom_range(3, 1);
         instr = 4'h6;
         for (int g = 0; g < gap; g++) step();
         n_vec++;
         if (op_vld !== 1'b0) begin
            n_err++; $display("FAIL gap_vld%0d got=%b exp=0", i, op_vld);
         end
         send_nib(nibs[i]);
      end
      n_vec++;
      if (op_vld !== 1'b1 || op !== 16'hBEEF) begin
         n_err++; $display("FAIL gap_op got=%b/%h exp=1/beef", op_vld, op);
      end
   endtask

   initial begin
      rst = 1'b1; instr = 4'h0; instr_vld = 1'b0; flush = 1'b0; op_acp = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_flush();
      test_flush_held();
      test_reset_mid();
      test_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
